// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/flow-control unit:
// controller state encoding and the hard-wired zero register address.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up until all-ones, then hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= {W{1'b0}};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and flow-control unit: data-memory freeze, taken-branch
// squash and load-use bubble, plus memory timeout and performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_write_addr,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int              WC_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_ONE    = {{(WC_W-1){1'b0}}, 1'b1};
    localparam logic [WC_W-1:0] TIMEOUT_V = WC_W'(MEM_TIMEOUT);

    state_t          state_r;
    logic [WC_W-1:0] wait_cnt_r;
    logic [WC_W-1:0] wait_inc_s;
    logic            frozen_s;
    logic            load_use_s;
    logic            stall_inc_s;
    logic            flush_inc_s;

    assign load_use_s = ex_mem_read && (ex_write_addr != REG_ZERO) &&
                        ((ex_write_addr == id_rs1) ||
                         (id_uses_rs2 && (ex_write_addr == id_rs2)));
    assign wait_inc_s = wait_cnt_r + WC_ONE;

    // Same-cycle control: freeze beats squash beats load-use; reset forces all low.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        case (state_r)
            RUN:      frozen_s = mem_req && !mem_ready;
            MEM_WAIT: frozen_s = !mem_ready;
            ERROR:    frozen_s = 1'b1;
            default:  frozen_s = 1'b1;
        endcase
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
        end else if (frozen_s) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use_s) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else begin
            idex_flush = 1'b0;
        end
    end

    assign stall_inc_s = (state_r != ERROR) &&
                         (frozen_s || (!ex_branch_taken && load_use_s));
    assign flush_inc_s = !frozen_s && ex_branch_taken;

    // Wait tracking: count consecutive not-ready cycles, trap into ERROR on timeout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= RUN;
            wait_cnt_r <= {WC_W{1'b0}};
            mem_error  <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        wait_cnt_r <= WC_ONE;
                        if (WC_ONE >= TIMEOUT_V) begin
                            state_r   <= ERROR;
                            mem_error <= 1'b1;
                        end else begin
                            state_r <= MEM_WAIT;
                        end
                    end else begin
                        wait_cnt_r <= {WC_W{1'b0}};
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state_r    <= RUN;
                        wait_cnt_r <= {WC_W{1'b0}};
                    end else begin
                        wait_cnt_r <= wait_inc_s;
                        if (wait_inc_s >= TIMEOUT_V) begin
                            state_r   <= ERROR;
                            mem_error <= 1'b1;
                        end else begin
                            state_r <= MEM_WAIT;
                        end
                    end
                end
                ERROR: begin
                    state_r <= ERROR;
                end
                default: begin
                    state_r   <= ERROR;
                    mem_error <= 1'b1;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc_s),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (flush_inc_s),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed corner sequences
// and a randomized run against a cycle-level reference model.
module tb_hazard_ctrl;

    localparam int CNT_W = 2;
    localparam int TO    = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    // control vector: {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, bubble}
    localparam logic [6:0] C_DEF = 7'b1101010;
    localparam logic [6:0] C_FRZ = 7'b0000001;
    localparam logic [6:0] C_SQ  = 7'b1111110;
    localparam logic [6:0] C_LU  = 7'b0001110;
    localparam logic [6:0] C_RST = 7'b0000000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_write_addr = 5'd0;
    logic id_uses_rs2 = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic mem_req = 1'b0, mem_ready = 1'b0;
    logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic exmem_write, memwb_bubble, mem_error;
    logic [CNT_W-1:0] stall_count, flush_count;

    int checks = 0;
    int fails  = 0;

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_write_addr(ex_write_addr),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_flush(idex_flush),
        .exmem_write(exmem_write), .memwb_bubble(memwb_bubble),
        .mem_error(mem_error), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] rs1, rs2, wa;
        logic uses, mr, br, req, rdy;
        logic [6:0] exp;
    } vec_t;

    function automatic logic [6:0] ctl();
        return {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                exmem_write, memwb_bubble};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                         input logic mr, input logic [4:0] wa, input logic br,
                         input logic req, input logic rdy);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = uses;
        ex_mem_read = mr; ex_write_addr = wa; ex_branch_taken = br;
        mem_req = req; mem_ready = rdy;
    endtask

    task automatic do_reset();
        @(negedge clock);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("reset_ctl", 32'(ctl()), 32'(C_RST));
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Apply inputs after the falling edge, check combinational controls, then clock.
    task automatic cyc(input string name, input logic [6:0] exp);
        #1;
        chk(name, 32'(ctl()), 32'(exp));
        @(posedge clock);
        #1;
    endtask

    vec_t vt[9];
    logic [4:0] r_rs1, r_rs2, r_wa;
    logic r_uses, r_mr, r_br, r_req, r_rdy;
    bit m_inwait, m_err, hz, fr, sq, lu;
    int m_waited, m_stall, m_flush, err_age;
    logic [6:0] m_exp;

    initial begin
        vt[0] = '{rs1:5'd5, rs2:5'd0, wa:5'd5, uses:1'b0, mr:1'b1, br:1'b0, req:1'b0, rdy:1'b0, exp:C_LU};
        vt[1] = '{rs1:5'd0, rs2:5'd0, wa:5'd0, uses:1'b1, mr:1'b1, br:1'b0, req:1'b0, rdy:1'b0, exp:C_DEF};
        vt[2] = '{rs1:5'd3, rs2:5'd5, wa:5'd5, uses:1'b0, mr:1'b1, br:1'b0, req:1'b0, rdy:1'b0, exp:C_DEF};
        vt[3] = '{rs1:5'd3, rs2:5'd5, wa:5'd5, uses:1'b1, mr:1'b1, br:1'b0, req:1'b0, rdy:1'b0, exp:C_LU};
        vt[4] = '{rs1:5'd5, rs2:5'd5, wa:5'd5, uses:1'b1, mr:1'b0, br:1'b0, req:1'b0, rdy:1'b0, exp:C_DEF};
        vt[5] = '{rs1:5'd1, rs2:5'd2, wa:5'd7, uses:1'b1, mr:1'b0, br:1'b1, req:1'b0, rdy:1'b0, exp:C_SQ};
        vt[6] = '{rs1:5'd7, rs2:5'd2, wa:5'd7, uses:1'b1, mr:1'b1, br:1'b1, req:1'b0, rdy:1'b0, exp:C_SQ};
        vt[7] = '{rs1:5'd9, rs2:5'd9, wa:5'd9, uses:1'b1, mr:1'b1, br:1'b0, req:1'b1, rdy:1'b1, exp:C_LU};
        vt[8] = '{rs1:5'd4, rs2:5'd6, wa:5'd8, uses:1'b1, mr:1'b1, br:1'b0, req:1'b0, rdy:1'b0, exp:C_DEF};

        #2;
        chk("reset_ctl0", 32'(ctl()), 32'(C_RST));
        chk("reset_err0", 32'(mem_error), 32'd0);
        chk("reset_stall0", 32'(stall_count), 32'd0);

        // Table of single-cycle RUN-state vectors.
        do_reset();
        foreach (vt[i]) begin
            @(negedge clock);
            drive(vt[i].rs1, vt[i].rs2, vt[i].uses, vt[i].mr, vt[i].wa, vt[i].br, vt[i].req, vt[i].rdy);
            cyc($sformatf("vec%0d", i), vt[i].exp);
        end
        chk("vec_stall", 32'(stall_count), 32'd3);
        chk("vec_flush", 32'(flush_count), 32'd2);

        // Load-use bubble then clear.
        do_reset();
        @(negedge clock); drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        cyc("lu_bubble", C_LU);
        chk("lu_stall", 32'(stall_count), 32'd1);
        @(negedge clock); ex_mem_read = 1'b0;
        cyc("lu_clear", C_DEF);
        chk("lu_stall_hold", 32'(stall_count), 32'd1);

        // Branch plus load-use in the same cycle.
        do_reset();
        @(negedge clock); drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        cyc("br_lu", C_SQ);
        chk("br_flush", 32'(flush_count), 32'd1);
        chk("br_stall", 32'(stall_count), 32'd0);

        // Three-cycle memory wait then release.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
            cyc($sformatf("wait%0d", i), C_FRZ);
        end
        @(negedge clock); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        cyc("wait_release", C_DEF);
        chk("wait_stall", 32'(stall_count), 32'd3);
        chk("wait_flush", 32'(flush_count), 32'd0);
        @(negedge clock); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("wait_run", C_DEF);

        // Timeout into ERROR, then asynchronous reset.
        do_reset();
        for (int i = 0; i < TO; i++) begin
            @(negedge clock); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            cyc($sformatf("to_wait%0d", i), C_FRZ);
            chk($sformatf("to_err%0d", i), 32'(mem_error), (i == TO - 1) ? 32'd1 : 32'd0);
        end
        @(negedge clock); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        cyc("err_hold", C_FRZ);
        chk("err_sticky", 32'(mem_error), 32'd1);
        @(negedge clock); #2; reset = 1'b1; #1;
        chk("async_ctl", 32'(ctl()), 32'(C_RST));
        chk("async_err", 32'(mem_error), 32'd0);
        chk("async_stall", 32'(stall_count), 32'd0);
        @(posedge clock); #1; reset = 1'b0;
        @(negedge clock); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("after_reset_run", C_DEF);

        // Saturation of the stall counter.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); drive(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
            cyc($sformatf("sat_lu%0d", i), C_LU);
            chk($sformatf("sat_cnt%0d", i), 32'(stall_count), (i < 3) ? 32'(i + 1) : 32'd3);
        end

        // Randomized run against the reference model.
        do_reset();
        m_inwait = 1'b0; m_err = 1'b0; m_waited = 0; m_stall = 0; m_flush = 0; err_age = 0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 60) == 0 || err_age > 3) begin
                do_reset();
                m_inwait = 1'b0; m_err = 1'b0; m_waited = 0; m_stall = 0; m_flush = 0; err_age = 0;
            end
            @(negedge clock);
            r_rs1 = 5'($urandom_range(0, 3)); r_rs2 = 5'($urandom_range(0, 3));
            r_wa = 5'($urandom_range(0, 3)); r_uses = 1'($urandom_range(0, 1));
            r_mr = 1'($urandom_range(0, 1)); r_br = ($urandom_range(0, 4) == 0);
            r_req = 1'($urandom_range(0, 1)); r_rdy = ($urandom_range(0, 2) != 0);
            drive(r_rs1, r_rs2, r_uses, r_mr, r_wa, r_br, r_req, r_rdy);

            hz = r_mr && (r_wa != 5'd0) && ((r_wa == r_rs1) || (r_uses && (r_wa == r_rs2)));
            fr = m_err || (!r_rdy && (m_inwait || r_req));
            sq = !fr && r_br;
            lu = !fr && !r_br && hz;
            m_exp = fr ? C_FRZ : (sq ? C_SQ : (lu ? C_LU : C_DEF));
            cyc("rnd_ctl", m_exp);

            if (!m_err) begin
                if (fr || lu) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
                if (sq) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
                if (fr) begin
                    m_waited++;
                    m_inwait = 1'b1;
                    if (m_waited >= TO) m_err = 1'b1;
                end else begin
                    m_inwait = 1'b0;
                    m_waited = 0;
                end
            end else begin
                err_age++;
            end
            chk("rnd_stall", 32'(stall_count), 32'(m_stall));
            chk("rnd_flush", 32'(flush_count), 32'(m_flush));
            chk("rnd_err", 32'(mem_error), 32'(m_err));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
